wave_capture: RTL

- Writer side of the double-buffered 512-entry waveform sample RAM that wave_display reads.
- Arms on a positive-going zero crossing of the incoming audio stream, then writes 256 consecutive samples (8-bit, display-scaled) into the RAM half that wave_display is not currently reading.
- Waits for the display to go idle, then flips read_index so the fresh capture is shown and the other half becomes the new write target.

---
 rtl/wave_capture.sv | 111 +++++++++++
 1 files changed

// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
//  Module   : wave_capture
//  Purpose  : Writer side of the double-buffered waveform sample RAM. Arms on
//             a positive-going zero crossing, captures 2^NUM_SAMPLES_LOG2
//             display-scaled samples into the half not being read, then flips
//             read_index once the display reports idle.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_capture #(
   parameter int SAMPLE_WIDTH     = 16,
   parameter int NUM_SAMPLES_LOG2 = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          new_sample_ready,
   input  logic signed [SAMPLE_WIDTH-1:0] new_sample_in,
   input  logic                          wave_display_idle,
   output logic [NUM_SAMPLES_LOG2:0]     write_address,
   output logic [7:0]                    write_sample,
   output logic                          write_enable,
   output logic                          read_index
);

   localparam int MSB = SAMPLE_WIDTH - 1;

   typedef enum logic [1:0] {
      S_ARMED  = 2'd0,
      S_ACTIVE = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t                      state;
   logic [NUM_SAMPLES_LOG2-1:0] offset;
   logic                        prev_negative;

   // Top 8 bits of the sample with the sign flipped gives offset-binary
   // data centred on 8'h80 for a zero-valued input.
   logic [7:0] scaled_sample;
   assign scaled_sample = {~new_sample_in[MSB], new_sample_in[MSB-1:MSB-7]};

   logic sample_negative;
   assign sample_negative = new_sample_in[MSB];

   // Bits below the top byte never reach the display.
   generate
      if (SAMPLE_WIDTH > 8) begin : g_unused_low
         logic unused_low_bits;
         assign unused_low_bits = ^new_sample_in[SAMPLE_WIDTH-9:0];
      end
   endgenerate

   // Capture sequencer: trigger detection, write generation and buffer flip.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_ARMED;
         offset        <= '0;
         prev_negative <= 1'b0;
         read_index    <= 1'b0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_sample  <= '0;
      end else begin
         write_enable <= 1'b0;

         // The sign history is tracked in every state so a crossing that
         // straddles the WAIT->ARMED flip is still recognised.
         if (new_sample_ready)
            prev_negative <= sample_negative;

         case (state)
            S_ARMED: begin
               if (new_sample_ready && prev_negative && !sample_negative) begin
                  write_enable  <= 1'b1;
                  write_address <= {~read_index, {NUM_SAMPLES_LOG2{1'b0}}};
                  write_sample  <= scaled_sample;
                  offset        <= NUM_SAMPLES_LOG2'(1);
                  state         <= S_ACTIVE;
               end
            end

            S_ACTIVE: begin
               if (new_sample_ready) begin
                  write_enable  <= 1'b1;
                  write_address <= {~read_index, offset};
                  write_sample  <= scaled_sample;
                  if (offset == {NUM_SAMPLES_LOG2{1'b1}}) begin
                     offset <= '0;
                     state  <= S_WAIT;
                  end else begin
                     offset <= offset + NUM_SAMPLES_LOG2'(1);
                  end
               end
            end

            S_WAIT: begin
               if (wave_display_idle) begin
                  read_index <= ~read_index;
                  state      <= S_ARMED;
               end
            end

            default: begin
               state <= S_ARMED;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
